// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and helpers for the key event generator.
// Holds the auto-repeat state enum and the counter width helper.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one push-button channel.
// Sync + debounce + press/release pulses; optional auto-repeat.
// Ports: clk, reset_n (async, active-low), key_n (raw, 0 = pressed),
//        held (debounced level), pressed / released (1-cycle pulses).
// Auto-repeat is compiled in when KEY_EVENT_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic held,
  output logic pressed,
  output logic released
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  logic [DW-1:0] dcnt;
  logic          accept;
  logic          rise;
  logic          fall;

  assign s      = sync[1];
  // Current edge is the last of a full run of differing samples.
  assign accept = (s != held) && (dcnt == DLAST);
  assign rise   = accept && !held;
  assign fall   = accept && held;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      dcnt     <= '0;
      held     <= 1'b0;
      released <= 1'b0;
    end else begin
      sync     <= {sync[0], ~key_n};
      released <= fall;
      if (s == held || accept) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      if (accept) begin
        held <= ~held;
      end
    end
  end

`ifdef KEY_EVENT_AUTOREPEAT_EN

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = cnt_w(TMAX);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  rpt_state_t    st;
  logic [TW-1:0] tmr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= IDLE;
      tmr     <= '0;
      pressed <= 1'b0;
    end else begin
      pressed <= rise;
      if (fall) begin
        // Release wins over any repeat due on the same edge.
        st      <= IDLE;
        tmr     <= '0;
        pressed <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            if (rise) begin
              st  <= DELAY;
              tmr <= '0;
            end
          end
          DELAY: begin
            if (tmr == DLY_LAST) begin
              pressed <= 1'b1;
              st      <= REPEAT;
              tmr     <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          REPEAT: begin
            if (tmr == PER_LAST) begin
              pressed <= 1'b1;
              tmr     <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: begin
            st  <= IDLE;
            tmr <= '0;
          end
        endcase
      end
    end
  end

`else

  // Repeat timing has no effect in this build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed <= 1'b0;
    end else begin
      pressed <= rise;
    end
  end

`endif

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: debounced press/release events for N_KEYS buttons.
// Ports: clk, reset_n (async, active-low), key_n[N_KEYS] raw (0 = pressed),
//        held / pressed / released [N_KEYS].
// Auto-repeat is compiled in when KEY_EVENT_AUTOREPEAT_EN is defined.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] released
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (key_n[i]),
      .held    (held[i]),
      .pressed (pressed[i]),
      .released(released[i])
    );
  end

endmodule
